// File: rtl/rtdf_pkg.sv
// Shared constants and helpers for the rtdf stream blocks.
package rtdf_pkg;

  localparam int RTDF_DEFAULT_WIDTH = 32'sd16;
  localparam int RTDF_DEFAULT_DEPTH = 32'sd16;

  // Number of address bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rtdf_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, never reset.
module rtdf_fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Store the write word on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/rtdf_sc_fifo.sv
// Single-clock show-ahead FIFO with occupancy thresholds and sticky error flags.
module rtdf_sc_fifo
  import rtdf_pkg::*;
#(
  parameter  int WIDTH    = RTDF_DEFAULT_WIDTH,
  parameter  int DEPTH    = RTDF_DEFAULT_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 32'sd2,
  parameter  int AE_LEVEL = 32'sd2,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclr,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      usedw,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_STEP = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_W     = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_W     = (AW+1)'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_STEP = (AW)'(1);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   usedw_r;
  logic          overflow_r;
  logic          underflow_r;

  logic empty_s;
  logic full_s;
  logic rd_acc_s;
  logic wr_acc_s;
  logic rd_en_s;
  logic wr_en_s;

  // Flag decode from registered occupancy plus request acceptance.
  always_comb begin
    empty_s  = (usedw_r == CNT_ZERO);
    full_s   = (usedw_r == CNT_FULL);
    rd_acc_s = rdreq & ~empty_s;
    // A read in the same cycle frees a slot, so a full FIFO can still take a write.
    wr_acc_s = wrreq & (~full_s | rd_acc_s);
    if (sclr) begin
      rd_en_s = 1'b0;
      wr_en_s = 1'b0;
    end else begin
      rd_en_s = rd_acc_s;
      wr_en_s = wr_acc_s;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      usedw_r  <= CNT_ZERO;
    end else if (sclr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      usedw_r  <= CNT_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_STEP;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_STEP;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   usedw_r <= usedw_r + CNT_STEP;
        2'b01:   usedw_r <= usedw_r - CNT_STEP;
        default: usedw_r <= usedw_r;
      endcase
    end
  end

  // Sticky error flags, cleared only by sclr or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (sclr) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  | (wrreq & ~wr_acc_s);
      underflow_r <= underflow_r | (rdreq & empty_s);
    end
  end

  rtdf_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (data),
    .raddr (rd_ptr_r),
    .rdata (q)
  );

  assign empty        = empty_s;
  assign full         = full_s;
  assign usedw        = usedw_r;
  assign almost_full  = (usedw_r >= AF_W);
  assign almost_empty = (usedw_r <= AE_W);
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
